lcm_issue_ctrl: RTL and testbench
=================================

// Module: lcm_issue_ctrl
// PURPOSE
//  Upstream feeder for the GCD/LCM core, which has no ready and must only see vld_in while idle.
//  Buffers operand pairs from a valid/ready stream in a small FIFO and drops zero-operand pairs,
//  because the core never terminates on a zero. Issues one pair at a time to the core, waits for
//  the core's completion pulse, and guards against a hung core with a timeout.
// PARAMETERS
//  DATA_W       8     operand width; must match the core's DATA_W
//  FIFO_DEPTH   4     operand-pair FIFO entries; power of 2, >= 2
//  TIMEOUT_CYC  512   max cycles in WAIT before abandoning the core; >= 2*2^DATA_W
// PORTS
//  clk           in   1                        single clock, rising edge
//  rst_n         in   1                        synchronous, active-low reset
//  s_valid       in   1                        upstream pair valid
//  s_ready       out  1                        upstream ready; = !full
//  s_a           in   DATA_W                   operand A
//  s_b           in   DATA_W                   operand B
//  core_vld_in   out  1                        one-cycle issue pulse to core vld_in
//  core_a        out  DATA_W                   to core A; held until the next issue
//  core_b        out  DATA_W                   to core B; held until the next issue
//  core_vld_out  in   1                        core completion (vld_out)
//  busy          out  1                        high in WAIT or DRAIN
//  fifo_level    out  $clog2(FIFO_DEPTH)+1     entries currently stored
//  err_zero      out  1                        one-cycle pulse: zero pair dropped
//  err_timeout   out  1                        one-cycle pulse: core timed out
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): FIFO emptied; FSM=IDLE; timeout counter=0.
//    Outputs: core_vld_in=0, core_a=0, core_b=0, busy=0, fifo_level=0, err_zero=0,
//    err_timeout=0, s_ready=1 from the next cycle.
//  - Reset mid-operation drops all queued pairs and any in-flight request.
//    rst_n is shared with the core, so both sides reset together.
//  - Accept = s_valid & s_ready at a clk edge.
//  - Accepted pair with s_a==0 or s_b==0: not written to the FIFO; err_zero=1 for the next cycle only.
//  - Any other accepted pair is written. FIFO order is strictly preserved.
//  - s_ready is combinational from fifo_level only (no dependence on pop). Full -> no push.
//  - Same-cycle push and pop: both take effect; fifo_level unchanged.
//  - Read/write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
//    full = (MSBs differ, remaining bits equal).
//  - FSM states: IDLE, WAIT, DRAIN.
//    IDLE:  if FIFO non-empty at an edge -> pop the head; register core_a/core_b <= head;
//           core_vld_in <= 1 for exactly one cycle; clear timeout counter; go to WAIT.
//    WAIT:  core_vld_out==1 -> go to DRAIN.
//           Otherwise increment the counter. When counter == TIMEOUT_CYC-1 ->
//           err_timeout=1 for one cycle and go to IDLE.
//    DRAIN: stay while core_vld_out==1; go to IDLE on the first edge with it 0.
//           The core holds vld_out for 2 cycles and recomputes lcm_out from its latched
//           operands, so no issue may overlap vld_out.
//  - Latency: pair accepted at edge N into an empty FIFO with FSM in IDLE ->
//    core_vld_in high in the cycle after edge N+1.
//  - Minimum spacing between issues: last core_vld_out-high cycle, then one cycle with it low,
//    then the issue edge.
//  - core_vld_out seen in IDLE (spurious) is ignored.
//  - busy=1 exactly in WAIT and DRAIN.
// TESTING (bench uses the real core, DATA_W=8, FIFO_DEPTH=4)
//  1. Single pair 12,18 -> core_vld_in 1 cycle after the accept edge; core_a=12, core_b=18.
//     Core gives mcd=6, lcm=36. busy falls 1 cycle after core_vld_out falls.
//  2. Six back-to-back pairs (12,18)(7,5)(9,3)(255,17)(64,48)(100,75) with s_valid held ->
//     s_ready=0 once level=4; all six reach the core in order.
//     Expected mcd 6,1,3,17,16,25.
//  3. Pair (0,5) then (8,12) -> err_zero pulses once for (0,5); fifo_level never counts it;
//     only (8,12) is issued (mcd=4, lcm=24).
//  4. Stub core never asserts vld_out, 2 pairs queued -> err_timeout after 512 WAIT cycles;
//     second pair issued 1 cycle later.
//  5. rst_n=0 for 1 edge during WAIT with 3 pairs queued -> next cycle: fifo_level=0, busy=0,
//     core_vld_in=0, s_ready=1; no further issue.
//  6. At fifo_level=2, push on the same edge as an IDLE pop -> level stays 2;
//     order checked by the issued operands.

Source files
------------

// File: rtl/lcm_issue_ctrl.sv
// Issue controller for the GCD/LCM core: buffers operand pairs, drops zero pairs,
// issues one pair at a time and waits for completion, with a timeout if the core hangs.
module lcm_issue_ctrl #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_a,
  input  logic [DATA_W-1:0]             s_b,
  output logic                          core_vld_in,
  output logic [DATA_W-1:0]             core_a,
  output logic [DATA_W-1:0]             core_b,
  input  logic                          core_vld_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_zero,
  output logic                          err_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       to_cnt_reg, to_cnt_next;
  logic                full, empty, accept, zero_pair, push, pop, timeout_hit;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign s_ready    = !full;
  assign accept     = s_valid && s_ready;
  assign zero_pair  = (s_a == '0) || (s_b == '0);
  assign push       = accept && !zero_pair;
  assign busy       = (state_reg == WAIT) || (state_reg == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          to_cnt_next = '0;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (core_vld_out) begin
          state_next = DRAIN;
        end else if (to_cnt_reg == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + CW'(1);
        end
      end
      // The core holds vld_out for two cycles; wait for it to drop before reissuing.
      DRAIN: begin
        if (!core_vld_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      to_cnt_reg  <= '0;
      core_vld_in <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      core_vld_in <= pop;
      err_zero    <= accept && zero_pair;
      err_timeout <= timeout_hit;
      to_cnt_reg  <= to_cnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        {core_a, core_b} <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {s_a, s_b};
  end
endmodule

// File: tb/tb_lcm_issue_ctrl.sv
// Bench for lcm_issue_ctrl with a behavioural GCD/LCM core (optionally stubbed silent)
// and a scoreboard that checks every issued pair in order.
`timescale 1ns/1ps
module tb_lcm_issue_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_a = '0;
  logic [DW-1:0] s_b = '0;
  logic          core_vld_in;
  logic [DW-1:0] core_a, core_b;
  logic          core_vld_out = 1'b0;
  logic          busy;
  logic [2:0]    fifo_level;
  logic          err_zero, err_timeout;

  lcm_issue_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT_CYC(512)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .core_vld_in(core_vld_in), .core_a(core_a), .core_b(core_b), .core_vld_out(core_vld_out),
    .busy(busy), .fifo_level(fifo_level), .err_zero(err_zero), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int a; int b; int mcd; int lcm;} exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   issue_cyc_q[$];
  int   issues = 0;
  int   cyc = 0;
  int   zero_pulses = 0;
  int   to_pulses = 0;
  int   to_cyc = 0;
  bit   saw_full = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gcd(input int x, input int y);
    int p = x;
    int q = y;
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: fixed-ish latency, vld_out held two cycles; silent when stubbed.
  logic core_stub = 1'b0;
  logic cm_busy = 1'b0;
  logic cm_hold = 1'b0;
  int   cm_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      core_vld_out <= 1'b0;
      cm_busy      <= 1'b0;
      cm_hold      <= 1'b0;
      cm_cnt       <= 0;
    end else begin
      if (core_vld_out) begin
        if (cm_hold) cm_hold <= 1'b0;
        else         core_vld_out <= 1'b0;
      end
      if (core_vld_in) begin
        cm_busy <= 1'b1;
        cm_cnt  <= 3 + int'(core_a[1:0]);
      end else if (cm_busy && !core_stub) begin
        if (cm_cnt != 0) cm_cnt <= cm_cnt - 1;
        else begin
          cm_busy      <= 1'b0;
          core_vld_out <= 1'b1;
          cm_hold      <= 1'b1;
        end
      end
    end
  end

  // Monitor: every issue pops the scoreboard and is checked against it.
  always @(negedge clk) begin
    if (rst_n && core_vld_in) begin
      issues++;
      issue_cyc_q.push_back(cyc);
      chk("issue_no_overlap", int'(core_vld_out), 0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got a=%0d b=%0d expected no issue", core_a, core_b);
      end else begin
        int g;
        mon_e = sb_q.pop_front();
        g = gcd(int'(core_a), int'(core_b));
        chk("issue_a", int'(core_a), mon_e.a);
        chk("issue_b", int'(core_b), mon_e.b);
        chk("issue_mcd", g, mon_e.mcd);
        chk("issue_lcm", (g == 0) ? 0 : int'(core_a) * int'(core_b) / g, mon_e.lcm);
        $display("ISSUE %0d: a=%0d b=%0d expect mcd=%0d lcm=%0d cyc=%0d",
                 issues, core_a, core_b, mon_e.mcd, mon_e.lcm, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_level == 3'd4) saw_full = 1'b1;
      chk("s_ready_vs_level", int'(s_ready), (fifo_level < 3'd4) ? 1 : 0);
      if (err_zero) zero_pulses++;
      if (err_timeout) begin
        to_pulses++;
        to_cyc = cyc;
      end
    end
  end

  // Present a pair from a negedge, hold until accepted; returns at the negedge after the accept.
  task automatic send(input int a, input int b, input int mcd, input int lcm, input bit exp_issue);
    int g = 0;
    s_valid = 1'b1;
    s_a = DW'(a);
    s_b = DW'(b);
    while (!s_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready) chk("send_ready_timeout", 0, 1);
    if (exp_issue) sb_q.push_back('{a, b, mcd, lcm});
    $display("SEND a=%0d b=%0d issue_expected=%0d", a, b, exp_issue);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string name);
    int g = 0;
    while ((busy || fifo_level != 0 || core_vld_in || core_vld_out) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk(name, (busy || fifo_level != 0) ? 1 : 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_core_vld_in", int'(core_vld_in), 0);
    chk("rst_core_a", int'(core_a), 0);
    chk("rst_core_b", int'(core_b), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_err_zero", int'(err_zero), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single pair latency and busy timing
    send(12, 18, 6, 36, 1'b1);
    s_valid = 1'b0;
    chk("t1_level_after_accept", int'(fifo_level), 1);
    chk("t1_no_issue_yet", int'(core_vld_in), 0);
    @(negedge clk);
    chk("t1_issue_latency", int'(core_vld_in), 1);
    chk("t1_busy_wait", int'(busy), 1);
    g = 0;
    while (!core_vld_out && g < 100) begin @(negedge clk); g++; end
    chk("t1_vld_out_seen", int'(core_vld_out), 1);
    while (core_vld_out && g < 200) begin @(negedge clk); g++; end
    chk("t1_busy_drain", int'(busy), 1);
    @(negedge clk);
    chk("t1_busy_fall", int'(busy), 0);
    wait_quiet("t1_quiet");

    // 2: six back-to-back pairs, FIFO fills
    saw_full = 1'b0;
    send(12, 18, 6, 36, 1'b1);
    send(7, 5, 1, 35, 1'b1);
    send(9, 3, 3, 9, 1'b1);
    send(255, 17, 17, 255, 1'b1);
    send(64, 48, 16, 192, 1'b1);
    send(100, 75, 25, 300, 1'b1);
    s_valid = 1'b0;
    wait_quiet("t2_quiet");
    chk("t2_saw_full", int'(saw_full), 1);

    // 3: zero pair dropped
    send(0, 5, 0, 0, 1'b0);
    s_valid = 1'b0;
    chk("t3_err_zero_pulse", int'(err_zero), 1);
    chk("t3_level_zero", int'(fifo_level), 0);
    @(negedge clk);
    chk("t3_err_zero_clear", int'(err_zero), 0);
    chk("t3_no_issue", int'(core_vld_in), 0);
    send(8, 12, 4, 24, 1'b1);
    s_valid = 1'b0;
    wait_quiet("t3_quiet");
    chk("t3_zero_pulse_count", zero_pulses, 1);

    // 4: hung core, timeout then next issue
    core_stub = 1'b1;
    n0 = issue_cyc_q.size();
    send(20, 30, 10, 60, 1'b1);
    send(21, 14, 7, 42, 1'b1);
    s_valid = 1'b0;
    g = 0;
    while (to_pulses == 0 && g < 800) begin @(negedge clk); g++; end
    chk("t4_timeout_seen", to_pulses, 1);
    if (issue_cyc_q.size() > n0) chk("t4_timeout_cycles", to_cyc - issue_cyc_q[n0], 512);
    else chk("t4_first_issue_seen", issue_cyc_q.size(), n0 + 1);
    @(negedge clk);
    chk("t4_err_timeout_clear", int'(err_timeout), 0);
    if (issue_cyc_q.size() > n0 + 1) chk("t4_reissue_gap", issue_cyc_q[n0 + 1] - to_cyc, 1);
    else chk("t4_second_issue_seen", issue_cyc_q.size(), n0 + 2);

    // 5: reset during WAIT with three pairs queued
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(40, 60, 20, 120, 1'b1);
    send(3, 3, 3, 3, 1'b0);
    send(5, 10, 5, 10, 1'b0);
    send(6, 9, 3, 18, 1'b0);
    s_valid = 1'b0;
    g = 0;
    while (!(busy && fifo_level == 3'd3) && g < 50) begin @(negedge clk); g++; end
    chk("t5_setup_level", int'(fifo_level), 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_level", int'(fifo_level), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_core_vld_in", int'(core_vld_in), 0);
    chk("t5_s_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    n0 = issues;
    repeat (30) @(negedge clk);
    chk("t5_no_further_issue", issues - n0, 0);

    // 6: push on the same edge as an IDLE pop at level 2
    core_stub = 1'b0;
    send(6, 4, 2, 12, 1'b1);
    send(15, 25, 5, 75, 1'b1);
    send(14, 21, 7, 42, 1'b1);
    s_valid = 1'b0;
    g = 0;
    while (!(!busy && fifo_level == 3'd2) && g < 100) begin @(negedge clk); g++; end
    chk("t6_idle_level2", int'(fifo_level), 2);
    send(36, 24, 12, 72, 1'b1);
    s_valid = 1'b0;
    chk("t6_level_unchanged", int'(fifo_level), 2);
    wait_quiet("t6_quiet");

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
